sram_stream_reader: RTL and testbench

- Bus master for the 8 KiB single-port track SRAM.
- Takes a start address and a byte count, then issues sequential SRAM reads with wrap-around at the end of the address space.
- Delivers the bytes as a valid/ready byte stream to the downstream MFM/bit serializer.
- An internal small FIFO absorbs the SRAM's 1-cycle registered read latency and consumer back-pressure.

---
 rtl/sram_stream_reader_pkg.sv | 17 +
 rtl/sram_stream_reader_sync_fifo.sv | 62 ++++++
 rtl/sram_stream_reader.sv | 142 ++++++++++++++
 tb/tb_sram_stream_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_reader_pkg.sv
// Shared constants for the track-SRAM stream reader: SRAM geometry, bus
// polarities and the reader FSM encoding.
package sram_stream_reader_pkg;

    localparam int   SRAM_SIZE     = 8192;
    localparam int   SRAM_ADDR_W   = $clog2(SRAM_SIZE);
    localparam int   SRAM_DATA_W   = 8;
    localparam logic RAM_RW_READ   = 1'b1;
    localparam logic RAM_EN_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sram_stream_reader_sync_fifo.sv
// Small synchronous FIFO with flush; carries {last,data} entries from the
// SRAM read pipeline to the output stream.
module sram_stream_reader_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        din_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        dout_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (count_q != FULL);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // flush takes priority over a same-cycle push so discarded reads never land
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Sequential reader for the track SRAM: reads length bytes from start_addr
// (wrapping at the top of the array) and streams them out with valid/ready.
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_rw,
    output logic              ram_en
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              rd_vld_p1_q, rd_last_p1_q;
    logic              done_q, done_d;
    logic              issue, last_issue, room, hs, head_last, flush;
    logic              start_go, start_zero;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W:0]   fifo_head;

    // FIFO slots are reserved for the read already in flight
    assign room       = (fifo_count + CNT_W'(rd_vld_p1_q)) < CNT_W'(FIFO_DEPTH);
    assign start_go   = (state_q == ST_IDLE) && start && (length != '0);
    assign start_zero = (state_q == ST_IDLE) && start && (length == '0);
    assign last_issue = issue && (rem_q == LEN_W'(1));
    assign head_last  = fifo_head[DATA_W];
    assign hs         = out_valid && out_ready;
    assign flush      = abort && (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_go) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (abort)           state_d = ST_IDLE;
                else if (last_issue) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort || (hs && head_last)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        issue = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                busy  = 1'b1;
                issue = !abort && (rem_q != '0) && room;
            end
            ST_DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (start_go) begin
            addr_d = start_addr;
            rem_d  = length;
        end else if (issue) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
        end
        done_d = start_zero || flush || ((state_q == ST_DRAIN) && hs && head_last);
    end

    // read issued in cycle N: SRAM registers at N+1, FIFO captures at N+2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            rem_q        <= '0;
            rd_vld_p1_q  <= 1'b0;
            rd_last_p1_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            rd_vld_p1_q  <= issue;
            rd_last_p1_q <= last_issue;
            done_q       <= done_d;
        end
    end

    sram_stream_reader_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (rd_vld_p1_q),
        .din_i   ({rd_last_p1_q, ram_dout}),
        .pop_i   (hs),
        .dout_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_head[DATA_W-1:0] : '0;
    assign out_last  = out_valid && head_last;
    assign done      = done_q;
    assign ram_addr  = addr_q;
    assign ram_din   = '0;
    assign ram_rw    = RAM_RW_READ;
    assign ram_en    = issue ? RAM_EN_ACTIVE : ~RAM_EN_ACTIVE;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: SRAM model, queue-based reference model with
// per-cycle compare, and directed transfers with literal expectations.
module tb_sram_stream_reader;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int MEMSZ = 8192;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, out_valid, out_last, ram_rw, ram_en;
    logic [DW-1:0] out_data, ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] sram [MEMSZ];
    int            rd_hits [MEMSZ];

    int checks = 0;
    int errors = 0;

    logic [DW:0]   exp_q[$];
    logic [DW:0]   acc_log[$];
    logic [AW-1:0] addr_log[$];
    bit            m_busy = 0, m_done = 0;
    int            m_rem = 0, m_out = 0, en_cycles = 0;
    logic [AW-1:0] m_addr = '0;

    sram_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .ram_rw     (ram_rw),
        .ram_en     (ram_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en == 1'b0) ram_dout <= sram[ram_addr];
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: outstanding = reads issued minus bytes accepted
    always @(negedge clk) begin
        logic [DW:0] head;
        bit          hs_last;
        if (rst) begin
            exp_q.delete();
            m_busy = 0; m_done = 0; m_rem = 0; m_out = 0; m_addr = '0;
        end else begin
            hs_last = 0;
            check("done", done, m_done);
            check("busy", busy, m_busy);
            if (!(m_busy && abort))
                check("ram_en", ram_en, (m_busy && m_rem > 0 && m_out < DEPTH) ? 0 : 1);
            if (ram_en == 1'b0) begin
                check("ram_addr", ram_addr, m_addr);
                addr_log.push_back(ram_addr);
                rd_hits[ram_addr]++;
                en_cycles++;
                m_addr = m_addr + 1'b1;
                m_rem--;
                m_out++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_valid: got 1 expected 0");
                end else begin
                    head = exp_q[0];
                    check("out_data", out_data, head[DW-1:0]);
                    check("out_last", out_last, head[DW]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        acc_log.push_back({out_last, out_data});
                        m_out--;
                        hs_last = head[DW];
                    end
                end
            end
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    if (length == 0) m_done = 1;
                    else begin
                        m_busy = 1; m_rem = int'(length); m_addr = start_addr; m_out = 0;
                        for (int i = 0; i < int'(length); i++) begin
                            logic [AW-1:0] a;
                            a = start_addr + AW'(i);
                            exp_q.push_back({i == int'(length) - 1, sram[a]});
                        end
                    end
                end
            end else if (abort) begin
                exp_q.delete();
                m_busy = 0; m_done = 1; m_rem = 0; m_out = 0;
            end else if (hs_last) begin
                m_busy = 0; m_done = 1;
            end
        end
    end

    task automatic run_xfer(input logic [AW-1:0] sa, input int len, input bit toggle,
                            input int maxc, output int first_k, output int done_k);
        first_k = -1;
        done_k  = -1;
        @(posedge clk); #1;
        acc_log.delete(); addr_log.delete(); en_cycles = 0;
        out_ready = 1'b1;
        start = 1'b1; start_addr = sa; length = (AW + 1)'(len);
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (out_valid && first_k < 0) first_k = k;
            if (done) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (toggle) out_ready = ~out_ready;
        end
        start = 1'b0;
        if (done_k < 0) begin
            checks++; errors++;
            $display("FAIL timeout: got no done expected done within %0d cycles", maxc);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fk, dk, bad;
        logic [DW:0]   t1_exp [4] = '{9'h010, 9'h011, 9'h012, 9'h113};
        logic [AW-1:0] t2_addr[4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        logic [DW:0]   t2_dat [4] = '{9'h0FE, 9'h0FF, 9'h000, 9'h101};
        for (int i = 0; i < MEMSZ; i++) begin
            sram[i]    = i[7:0];
            rd_hits[i] = 0;
        end

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ram_en", ram_en, 1);
        check("rst_ram_rw", ram_rw, 1);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        run_xfer(13'h010, 4, 0, 50, fk, dk);
        check("t1_first_valid", fk, 3);
        check("t1_done_cycle", dk, 7);
        check("t1_en_cycles", en_cycles, 4);
        check("t1_count", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) check("t1_byte", acc_log[i], t1_exp[i]);

        run_xfer(13'h1FFE, 4, 0, 50, fk, dk);
        check("t2_count", acc_log.size(), 4);
        check("t2_reads", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) check("t2_addr", addr_log[i], t2_addr[i]);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) check("t2_byte", acc_log[i], t2_dat[i]);

        run_xfer(13'h020, 16, 1, 200, fk, dk);
        check("t3_count", acc_log.size(), 16);
        check("t3_en_cycles", en_cycles, 16);
        for (int i = 0; i < 16 && i < acc_log.size(); i++)
            check("t3_byte", acc_log[i], {i == 15, 8'h20 + 8'(i)});

        run_xfer(13'h005, 0, 0, 10, fk, dk);
        check("t4_done_cycle", dk, 1);
        check("t4_en_cycles", en_cycles, 0);
        check("t4_valid_seen", fk, -1);
        check("t4_busy", busy, 0);

        @(posedge clk); #1;
        acc_log.delete(); addr_log.delete(); en_cycles = 0;
        out_ready = 1'b1; start = 1'b1; start_addr = 13'h100; length = 14'd100;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 200 && acc_log.size() < 10; k++) begin
            @(posedge clk); #1;
        end
        check("t5_accepted", acc_log.size(), 10);
        abort = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 abort = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("t5_valid_after_abort", out_valid, 0);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        if (acc_log.size() >= 10) check("t5_tenth", acc_log[9], 9'h009);
        run_xfer(13'h000, 2, 0, 50, fk, dk);
        check("t5b_count", acc_log.size(), 2);
        if (acc_log.size() >= 2) begin
            check("t5b_b0", acc_log[0], 9'h000);
            check("t5b_b1", acc_log[1], 9'h101);
        end

        @(posedge clk); #1;
        start = 1'b1; start_addr = 13'h300; length = 14'd100;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("t6_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_valid", out_valid, 0);
        check("t6_last", out_last, 0);
        check("t6_data", out_data, 0);
        check("t6_ram_en", ram_en, 1);
        check("t6_ram_addr", ram_addr, 0);
        @(posedge clk); #3 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_no_done", done, 0);
        end

        for (int i = 0; i < MEMSZ; i++) rd_hits[i] = 0;
        run_xfer(13'h0AAA, 8192, 0, 9000, fk, dk);
        bad = 0;
        for (int i = 0; i < MEMSZ; i++) if (rd_hits[i] != 1) bad++;
        check("t7_addr_once", bad, 0);
        check("t7_count", acc_log.size(), 8192);
        check("t7_reads", addr_log.size(), 8192);
        if (acc_log.size() == 8192) begin
            check("t7_first", acc_log[0], 9'h0AA);
            check("t7_final", acc_log[8191], 9'h1A9);
        end
        if (addr_log.size() == 8192) check("t7_last_addr", addr_log[8191], 13'h0AA9);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
